// File: rtl/cpu_pkg.sv
// +------------------------------------------------------------------+
// | cpu_pkg: ALU function encodings and the shared register-index width |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
// +------------------------------------------------------------------+
// | alu_issue_stage_if: decode-side and ALU-side handshake bundle      |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

interface alu_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 6,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [REG_W-1:0] rs_idx;
  logic [REG_W-1:0] rt_idx;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic [4:0]       shamt;
  logic             alu_src1;
  logic             alu_src2;
  logic [FUN_W-1:0] fun_in;
  logic             sign_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [FUN_W-1:0] ALUFun;
  logic             Sign;

  modport master (
    output in_valid, rs_idx, rt_idx, rs_data, rt_data, imm, shamt,
           alu_src1, alu_src2, fun_in, sign_in, out_ready,
    input  in_ready, out_valid, A, B, ALUFun, Sign
  );

  modport slave (
    input  in_valid, rs_idx, rt_idx, rs_data, rt_data, imm, shamt,
           alu_src1, alu_src2, fun_in, sign_in, out_ready,
    output in_ready, out_valid, A, B, ALUFun, Sign
  );
endinterface

`default_nettype wire

// File: rtl/operand_fwd_mux.sv
// +------------------------------------------------------------------+
// | operand_fwd_mux: picks EX/MEM, MEM/WB or register-file data        |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = cpu_pkg::REG_W
) (
  input  wire logic [IDX_W-1:0] idx,
  input  wire logic [WIDTH-1:0] reg_data,
  input  wire logic             ex_we,
  input  wire logic [IDX_W-1:0] ex_rd,
  input  wire logic [WIDTH-1:0] ex_data,
  input  wire logic             wb_we,
  input  wire logic [IDX_W-1:0] wb_rd,
  input  wire logic [WIDTH-1:0] wb_data,
  output logic      [WIDTH-1:0] value
);

  // Register 0 is hard-wired, so a write to it must never shadow the file read.
  always_comb begin
    value = reg_data;
    if (ex_we && (ex_rd != '0) && (ex_rd == idx)) begin
      value = ex_data;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == idx)) begin
      value = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +------------------------------------------------------------------+
// | alu_issue_stage: ID/EX operand resolve + 2-entry skid buffer       |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FUN_W = 6,
  parameter int IDX_W = cpu_pkg::REG_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush,
  input  wire logic             ex_we,
  input  wire logic [IDX_W-1:0] ex_rd,
  input  wire logic [WIDTH-1:0] ex_data,
  input  wire logic             wb_we,
  input  wire logic [IDX_W-1:0] wb_rd,
  input  wire logic [WIDTH-1:0] wb_data,
  alu_issue_stage_if.slave      bus
);

  logic [IDX_W-1:0] src_idx  [2];
  logic [WIDTH-1:0] src_data [2];
  logic [WIDTH-1:0] src_fwd  [2];

  assign src_idx[0]  = bus.rs_idx;
  assign src_idx[1]  = bus.rt_idx;
  assign src_data[0] = bus.rs_data;
  assign src_data[1] = bus.rt_data;

  for (genvar s = 0; s < 2; s++) begin : g_src
    operand_fwd_mux #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_fwd (
      .idx      (src_idx[s]),
      .reg_data (src_data[s]),
      .ex_we    (ex_we),
      .ex_rd    (ex_rd),
      .ex_data  (ex_data),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .value    (src_fwd[s])
    );
  end

  logic [WIDTH-1:0] new_a;
  logic [WIDTH-1:0] new_b;

  assign new_a = bus.alu_src1 ? {{(WIDTH-5){1'b0}}, bus.shamt} : src_fwd[0];
  assign new_b = bus.alu_src2 ? bus.imm : src_fwd[1];

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_a, main_b, skid_a, skid_b;
  logic [FUN_W-1:0] main_fun, skid_fun;
  logic             main_sign, skid_sign;
  logic             accept;

  // in_ready depends only on a flop, so out_ready never reaches it combinationally.
  assign accept = bus.in_valid && !skid_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_a     <= '0;
      main_b     <= '0;
      main_fun   <= '0;
      main_sign  <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_fun   <= '0;
      skid_sign  <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (bus.out_ready) begin
        main_a     <= skid_a;
        main_b     <= skid_b;
        main_fun   <= skid_fun;
        main_sign  <= skid_sign;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid && !bus.out_ready) begin
        skid_a     <= new_a;
        skid_b     <= new_b;
        skid_fun   <= bus.fun_in;
        skid_sign  <= bus.sign_in;
        skid_valid <= 1'b1;
      end else begin
        main_a     <= new_a;
        main_b     <= new_b;
        main_fun   <= bus.fun_in;
        main_sign  <= bus.sign_in;
        main_valid <= 1'b1;
      end
    end else if (bus.out_ready) begin
      main_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.A         = main_a;
  assign bus.B         = main_b;
  assign bus.ALUFun    = main_fun;
  assign bus.Sign      = main_sign;

endmodule

`default_nettype wire
